// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the APB timer counting core.
//   tmr_state_e  : counter FSM states
//   FLG_*        : bit positions inside the {cmp, udf, ovf} flag vector
//   CNT_W_DEF    : default counter width
package timer_pkg;

    localparam int unsigned CNT_W_DEF = 32;

    localparam int unsigned FLG_OVF = 0;
    localparam int unsigned FLG_UDF = 1;
    localparam int unsigned FLG_CMP = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } tmr_state_e;

endpackage

// File: rtl/tick_edge_det.sv
// tick_edge_det: turns a level-sampled divided clock into a one-clk pulse
// per rising edge.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   tick_in  in  divided clock, sampled as a level
//   tick     out one-cycle pulse per rising edge of tick_in
// EDGE_REG=1 adds a sample register in front of the detector (+1 clk).
module tick_edge_det #(
    parameter int unsigned EDGE_REG = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    output logic tick
);

    logic t;
    logic t_q;

    if (EDGE_REG != 0) begin : g_sample
        logic t_r;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) t_r <= 1'b0;
            else        t_r <= tick_in;
        end
        assign t = t_r;
    end else begin : g_raw
        assign t = tick_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) t_q <= 1'b0;
        else        t_q <= t;
    end

    assign tick = t & ~t_q;

endmodule

// File: rtl/timer_counter.sv
// timer_counter: counting core of the APB timer.
//   clk, rst_n  system clock, asynchronous active-low reset
//   tick_in     prescaler output, sampled as a level
//   cnt_en      run (1) / stop and hold (0)
//   dir_down    0 = up, 1 = down
//   one_shot    stop in DONE after the first wrap
//   load        single-cycle pulse, cnt <= load_val (beats a same-cycle tick)
//   load_val    load value
//   cmp_val     compare value
//   int_en      interrupt enables {cmp, udf, ovf}
//   flag_clr    single-cycle clear pulses {cmp, udf, ovf}
//   cnt         current count
//   running     1 while in RUN
//   flags       sticky {cmp, udf, ovf}
//   irq         registered OR of flags & int_en
module timer_counter
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned EDGE_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             cnt_en,
    input  logic             dir_down,
    input  logic             one_shot,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] cmp_val,
    input  logic [2:0]       int_en,
    input  logic [2:0]       flag_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             running,
    output logic [2:0]       flags,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    tmr_state_e       state;
    tmr_state_e       state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       flg_set;
    logic             cnt_upd;
    logic             wrap;
    logic             tick;

    tick_edge_det #(
        .EDGE_REG (EDGE_REG)
    ) u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_in (tick_in),
        .tick    (tick)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flg_set   = '0;
        cnt_upd   = 1'b0;
        wrap      = 1'b0;

        // Load wins over a tick in the same cycle; the tick is dropped.
        // A tick with cnt_en low is ignored even though RUN is still current.
        if (load) begin
            cnt_nxt = load_val;
            cnt_upd = 1'b1;
        end else if (state == RUN && cnt_en && tick) begin
            cnt_upd = 1'b1;
            if (dir_down) begin
                cnt_nxt          = cnt - CNT_ONE;
                wrap             = (cnt == '0);
                flg_set[FLG_UDF] = wrap;
            end else begin
                cnt_nxt          = cnt + CNT_ONE;
                wrap             = (cnt == '1);
                flg_set[FLG_OVF] = wrap;
            end
        end

        // Compare only fires on an actual update, not on static equality.
        if (cnt_upd && cnt_nxt == cmp_val) flg_set[FLG_CMP] = 1'b1;

        case (state)
            IDLE:    if (cnt_en) state_nxt = RUN;
            RUN: begin
                if (!cnt_en)              state_nxt = IDLE;
                else if (wrap && one_shot) state_nxt = DONE;
            end
            DONE:    if (!cnt_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            flags   <= '0;
            irq     <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            // Set is OR-ed after the clear so a colliding set survives.
            flags   <= (flags & ~flag_clr) | flg_set;
            irq     <= |(flags & int_en);
            running <= (state_nxt == RUN);
        end
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Counting core of the APB timer.
- Consumes the prescaler's divided clock output, which it samples as a level in the same clk domain.
- Advances a counter once per rising edge of that signal.
- Raises sticky overflow, underflow and compare-match flags, and drives a combined interrupt request to the APB register block.

Parameters:
CNT_W, 32, counter, load value and compare value width (legal range 8..64)
EDGE_REG, 1, 1 = register tick_in before edge detection (+1 cycle latency); 0 = detect on raw input

Ports:
clk  input  1  system clock, the same clock that feeds the prescaler
rst_n  input  1  asynchronous active-low reset
tick_in  input  1  prescaler clk_out, sampled as a level
cnt_en  input  1  1 = run; 0 = stop and hold the count
dir_down  input  1  0 = count up, 1 = count down
one_shot  input  1  1 = stop after the first wrap
load  input  1  single-cycle pulse: cnt <= load_val
load_val  input  CNT_W  value applied on load
cmp_val  input  CNT_W  compare value
int_en  input  3  interrupt enables {cmp, udf, ovf}
flag_clr  input  3  single-cycle clear pulses {cmp, udf, ovf}
cnt  output  CNT_W  current count
running  output  1  1 when the FSM is in RUN
flags  output  3  sticky flags {cmp, udf, ovf}
irq  output  1  OR of (flags & int_en), registered

Behaviour:
- Reset values: cnt=0, flags=0, irq=0, running=0, edge-detect history=0, FSM=IDLE. Reset mid-count aborts immediately; no flag survives reset.
- Tick generation: tick = t & ~t_q.
  - t is tick_in (EDGE_REG=0) or its registered copy (EDGE_REG=1).
  - One tick per rising edge of tick_in.
  - tick_in held constant high or low produces no ticks.
  - tick_in toggling every clk (prescaler divide-by-2) gives one tick every 2 clks.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when cnt_en=1.
  - RUN -> IDLE when cnt_en=0.
  - RUN -> DONE on a wrap while one_shot=1.
  - DONE -> IDLE when cnt_en=0. DONE ignores ticks.
  - running=1 only in RUN, and is registered (reflects state after transition).
- Counting, in RUN on a tick:
  - Up: cnt+1. From all-ones, cnt becomes 0 and the ovf flag sets.
  - Down: cnt-1. From 0, cnt becomes all-ones and the udf flag sets.
- Compare: the cmp flag sets in the cycle cnt is updated to a value equal to cmp_val, on a tick or a load. A static equality with no cnt update does not re-set the flag.
- Latency: tick_in rising to cnt updated is 1 clk (EDGE_REG=0) or 2 clk (EDGE_REG=1). flags update in the same cycle as cnt. irq follows flags by 1 clk.
- Load:
  - Takes effect in any state.
  - Has priority over a same-cycle tick, which is dropped.
  - Never sets ovf or udf.
  - Sets cmp if load_val == cmp_val.
  - Does not change the FSM state.
- Flags:
  - Sticky until cleared by the matching flag_clr bit.
  - A set and a clear of the same flag in the same cycle leaves the flag set (the set wins).
  - Clearing one bit never affects the others.
- cnt_en falling with a same-cycle tick: the tick is ignored. Count holds in IDLE and DONE.
- Width: all arithmetic is modulo 2^CNT_W, unsigned, with no saturation.

Decomposition:
- timer_pkg holds:
  - state enum tmr_state_e {IDLE, RUN, DONE};
  - flag bit index constants FLG_OVF=0, FLG_UDF=1, FLG_CMP=2;
  - default CNT_W.
- Sub-module tick_edge_det (params EDGE_REG; ports clk, rst_n, tick_in, tick) isolates the optional sample register and rising-edge pulse. The prescaler bench and this block can both reuse it.

Test Plan:
- Edge detection, EDGE_REG=1: tick_in toggles every 20ns (clk 20ns period), cnt_en=1, up, load_val=0 -> cnt increments once per 2 clks; cnt=5 after 5 rising edges of tick_in.
- Overflow: CNT_W=8, load 8'hFE, up, 3 ticks -> cnt FF,00,01; flags[0] sets on the 00 cycle; irq=1 one clk later with int_en=3'b001.
- Underflow with one-shot: load 8'h01, dir_down=1, one_shot=1, 4 ticks -> cnt 00,FF then holds; flags[1]=1; running drops to 0 in DONE; cnt_en 0->1 restarts via IDLE.
- Compare and clear collision: cmp_val=8'h10, load 8'h0E, 2 ticks -> flags[2]=1 at cnt=10; a flag_clr[2] pulse in the same cycle as a re-match leaves flags[2]=1.
- Load priority: load=1 with load_val=8'h40 in the same cycle as a tick -> cnt=40, not 41, and no ovf.
- Async reset mid-run: assert rst_n=0 between clk edges with cnt=8'h33 and flags=3'b101 -> all outputs 0 immediately; after release, no ticks counted until the next tick_in rising edge.
